// File: rtl/i2s_clk_gen_if.sv
// Control/status bundle for i2s_clk_gen: run request, runtime config, clocks and strobes.
// Optional index outputs exist only when I2S_CLK_GEN_IDX_EN is defined.
interface i2s_clk_gen_if #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_BITS = 32,
  parameter int DIV_W     = 10
);
  localparam int SLOT_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
  localparam int BIDX_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;

  logic             en_in;
  logic [DIV_W-1:0] cfg_half_div_in;
  logic             cfg_fmt_in;
  logic             busy_out;
  logic             sclk_out;
  logic             lrck_out;
  logic             sclk_rise_out;
  logic             sclk_fall_out;
  logic             frame_start_out;
`ifdef I2S_CLK_GEN_IDX_EN
  logic [SLOT_W-1:0] slot_idx_out;
  logic [BIDX_W-1:0] bit_idx_out;

  modport master (
    input  en_in, cfg_half_div_in, cfg_fmt_in,
    output busy_out, sclk_out, lrck_out, sclk_rise_out, sclk_fall_out,
           frame_start_out, slot_idx_out, bit_idx_out
  );
  modport slave (
    output en_in, cfg_half_div_in, cfg_fmt_in,
    input  busy_out, sclk_out, lrck_out, sclk_rise_out, sclk_fall_out,
           frame_start_out, slot_idx_out, bit_idx_out
  );
`else
  modport master (
    input  en_in, cfg_half_div_in, cfg_fmt_in,
    output busy_out, sclk_out, lrck_out, sclk_rise_out, sclk_fall_out,
           frame_start_out
  );
  modport slave (
    output en_in, cfg_half_div_in, cfg_fmt_in,
    input  busy_out, sclk_out, lrck_out, sclk_rise_out, sclk_fall_out,
           frame_start_out
  );
`endif
endinterface

// File: rtl/i2s_clk_gen.sv
// Runtime-programmable I2S/TDM SCLK/LRCK generator in the MCLK domain, starting/stopping on frame
// boundaries. Define I2S_CLK_GEN_IDX_EN to add registered slot/bit index outputs.
module i2s_clk_gen #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_BITS = 32,
  parameter int DIV_W     = 10
) (
  input  logic           mclk_in,
  input  logic           arstn_in,
  i2s_clk_gen_if.master  bus
);
  localparam int FRAME_BITS = NUM_SLOTS * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic [DIV_W-1:0] r_half, w_half_nxt;
  logic             r_fmt, w_fmt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_lrck, w_lrck_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_fs, w_fs_nxt;
  logic [DIV_W-1:0] w_half_m1;
  logic             w_div_last;

  // Frame-relative LRCK level; I2S looks one bit ahead so LRCK leads the MSB.
  function automatic logic lr(input logic [BIT_W-1:0] b, input logic fmt);
    logic [BIT_W-1:0] bb;
    if (fmt)
      bb = b;
    else
      bb = (b == LAST_BIT) ? '0 : b + BIT_W'(1);
    return (int'(bb) / SLOT_BITS) >= (NUM_SLOTS / 2);
  endfunction

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  assign w_half_m1  = r_half - DIV_W'(1);
  assign w_div_last = (r_div_cnt == w_half_m1);

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_half_nxt  = r_half;
    w_fmt_nxt   = r_fmt;
    w_busy_nxt  = r_busy;
    w_sclk_nxt  = r_sclk;
    w_lrck_nxt  = r_lrck;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_fs_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_nxt  = '0;
        w_bit_nxt  = '0;
        w_busy_nxt = 1'b0;
        w_sclk_nxt = 1'b0;
        w_lrck_nxt = 1'b0;
        if (bus.en_in) begin
          w_state_nxt = S_RUN;
          w_half_nxt  = clamp_div(bus.cfg_half_div_in);
          w_fmt_nxt   = bus.cfg_fmt_in;
          w_busy_nxt  = 1'b1;
          w_fs_nxt    = 1'b1;
          w_lrck_nxt  = lr('0, bus.cfg_fmt_in);
        end
      end
      S_RUN: begin
        if (!w_div_last) begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end else begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
            w_rise_nxt = 1'b1;
          end else if (r_bit_cnt != LAST_BIT) begin
            w_sclk_nxt = 1'b0;
            w_fall_nxt = 1'b1;
            w_bit_nxt  = r_bit_cnt + BIT_W'(1);
            w_lrck_nxt = lr(r_bit_cnt + BIT_W'(1), r_fmt);
          end else if (bus.en_in) begin
            // Back-to-back frame: config is only sampled here, never mid-frame.
            w_sclk_nxt = 1'b0;
            w_fall_nxt = 1'b1;
            w_bit_nxt  = '0;
            w_fs_nxt   = 1'b1;
            w_half_nxt = clamp_div(bus.cfg_half_div_in);
            w_fmt_nxt  = bus.cfg_fmt_in;
            w_lrck_nxt = lr('0, bus.cfg_fmt_in);
          end else begin
            w_state_nxt = S_IDLE;
            w_sclk_nxt  = 1'b0;
            w_bit_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_lrck_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_half    <= DIV_W'(1);
      r_fmt     <= 1'b0;
      r_busy    <= 1'b0;
      r_sclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_half    <= w_half_nxt;
      r_fmt     <= w_fmt_nxt;
      r_busy    <= w_busy_nxt;
      r_sclk    <= w_sclk_nxt;
      r_lrck    <= w_lrck_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_fs      <= w_fs_nxt;
    end
  end

  assign bus.busy_out        = r_busy;
  assign bus.sclk_out        = r_sclk;
  assign bus.lrck_out        = r_lrck;
  assign bus.sclk_rise_out   = r_rise;
  assign bus.sclk_fall_out   = r_fall;
  assign bus.frame_start_out = r_fs;

`ifdef I2S_CLK_GEN_IDX_EN
  localparam int SLOT_W = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
  localparam int BIDX_W = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;

  logic [SLOT_W-1:0] r_slot_idx, w_slot_nxt;
  logic [BIDX_W-1:0] r_bit_idx, w_bidx_nxt;

  // Indices track the next bit counter so they stay aligned with r_bit_cnt.
  always_comb begin
    w_slot_nxt = '0;
    w_bidx_nxt = '0;
    if (w_state_nxt == S_RUN) begin
      w_slot_nxt = SLOT_W'(int'(w_bit_nxt) / SLOT_BITS);
      w_bidx_nxt = BIDX_W'(SLOT_BITS - 1 - (int'(w_bit_nxt) % SLOT_BITS));
    end
  end

  always_ff @(posedge mclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_slot_idx <= '0;
      r_bit_idx  <= '0;
    end else begin
      r_slot_idx <= w_slot_nxt;
      r_bit_idx  <= w_bidx_nxt;
    end
  end

  assign bus.slot_idx_out = r_slot_idx;
  assign bus.bit_idx_out  = r_bit_idx;
`endif
endmodule

// File: tb/tb_i2s_clk_gen.sv
// Self-checking bench for i2s_clk_gen: every cycle compared against a frame-time arithmetic model.
module tb_i2s_clk_gen;
  localparam int NUM_SLOTS  = 2;
  localparam int SLOT_BITS  = 32;
  localparam int DIV_W      = 10;
  localparam int FRAME_BITS = NUM_SLOTS * SLOT_BITS;

  logic mclk = 1'b0;
  logic arstn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Model: position in the current frame measured in MCLK cycles since frame start.
  bit m_run   = 1'b0;
  int m_t     = 0;
  int m_h     = 1;
  bit m_fmt   = 1'b0;
  bit m_first = 1'b0;

  i2s_clk_gen_if #(.NUM_SLOTS(NUM_SLOTS), .SLOT_BITS(SLOT_BITS), .DIV_W(DIV_W)) bus ();

  i2s_clk_gen #(.NUM_SLOTS(NUM_SLOTS), .SLOT_BITS(SLOT_BITS), .DIV_W(DIV_W)) dut (
    .mclk_in  (mclk),
    .arstn_in (arstn),
    .bus      (bus)
  );

  always #5 mclk = ~mclk;

  function automatic bit lr(input int b, input bit fmt);
    int bb;
    bb = fmt ? b : (b + 1) % FRAME_BITS;
    return (bb / SLOT_BITS) >= (NUM_SLOTS / 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    int p, ph, b;
    p  = 2 * m_h;
    ph = m_t % p;
    b  = m_t / p;
    chk("busy",  bus.busy_out,        m_run);
    chk("sclk",  bus.sclk_out,        m_run && ph >= m_h);
    chk("rise",  bus.sclk_rise_out,   m_run && ph == m_h);
    chk("fall",  bus.sclk_fall_out,   m_run && ph == 0 && !(m_t == 0 && m_first));
    chk("fs",    bus.frame_start_out, m_run && m_t == 0);
    chk("lrck",  bus.lrck_out,        m_run && lr(b, m_fmt));
`ifdef I2S_CLK_GEN_IDX_EN
    chk("slot",  32'(bus.slot_idx_out), m_run ? b / SLOT_BITS : 0);
    chk("bidx",  32'(bus.bit_idx_out),  m_run ? SLOT_BITS - 1 - (b % SLOT_BITS) : 0);
`endif
  endtask

  task automatic model_edge();
    int cfg;
    cfg = int'(bus.cfg_half_div_in);
    if (!m_run) begin
      if (bus.en_in) begin
        m_run = 1'b1; m_t = 0; m_first = 1'b1;
        m_h = (cfg == 0) ? 1 : cfg;
        m_fmt = bus.cfg_fmt_in;
      end
    end else begin
      m_t++;
      if (m_t == FRAME_BITS * 2 * m_h) begin
        if (bus.en_in) begin
          m_t = 0; m_first = 1'b0;
          m_h = (cfg == 0) ? 1 : cfg;
          m_fmt = bus.cfg_fmt_in;
        end else begin
          m_run = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      if (arstn) model_edge();
      @(negedge mclk);
      check_all();
    end
  endtask

  task automatic pulse_reset();
    #2 arstn = 1'b0;
    m_run = 1'b0;
    #1 check_all();
    step(2);
    arstn = 1'b1;
  endtask

  initial begin
    bus.en_in = 1'b0;
    bus.cfg_half_div_in = DIV_W'(2);
    bus.cfg_fmt_in = 1'b1;
    step(3);
    @(negedge mclk);
    arstn = 1'b1;

    // Left-justified, H=2: 256-cycle frames.
    bus.en_in = 1'b1;
    step(2 * 256 + 10);

    // I2S framing takes effect at the next frame start.
    bus.cfg_fmt_in = 1'b0;
    step(2 * 256);

    // half_div=0 behaves as 1.
    bus.cfg_half_div_in = '0;
    step(300);

    // Back to H=2, then stop request at bit 10.
    bus.cfg_half_div_in = DIV_W'(2);
    bus.cfg_fmt_in = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (m_run && m_h == 2 && m_t == 10 * 4) break;
      step(1);
    end
    bus.en_in = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!m_run) break;
      step(1);
    end
    step(20);
    bus.en_in = 1'b1;
    step(1);
    chk("restart_fs", bus.frame_start_out, 1'b1);

    // Mid-frame divider change 2->3.
    step(100);
    bus.cfg_half_div_in = DIV_W'(3);
    step(1000);

    // Async reset mid-frame, release with en=1.
    step(37);
    pulse_reset();
    step(400);

    // Randomized configuration, run/stop and reset sequences.
    for (int k = 0; k < 10; k++) begin
      bus.cfg_half_div_in = DIV_W'($urandom_range(0, 3));
      bus.cfg_fmt_in = 1'($urandom_range(0, 1));
      bus.en_in = ($urandom_range(0, 3) != 0);
      step($urandom_range(20, 700));
      if ($urandom_range(0, 3) == 0) pulse_reset();
    end

    bus.en_in = 1'b0;
    step(1600);
    chk("final_idle", bus.busy_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
